// File: rtl/inst_fetch_pkg.sv
// Shared widths, PC step, FSM encoding and FIFO entry type for the fetch unit.
// Defining FETCH_PREFETCH_EN deepens the fetch FIFO from 1 to 4 entries (prefetch through stalls).
package inst_fetch_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_WIDTH      = 32;

  localparam logic [INST_ADDR_WIDTH-1:0] PC_INC = INST_ADDR_WIDTH'(4);

`ifdef FETCH_PREFETCH_EN
  localparam int FETCH_DEPTH = 4;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] addr;
    logic [INST_WIDTH-1:0]      inst;
  } fetch_entry_t;

  // Fetch addresses are word aligned; the low two bits of a target are dropped.
  function automatic logic [INST_ADDR_WIDTH-1:0] align_pc(input logic [INST_ADDR_WIDTH-1:0] a);
    return a & ~INST_ADDR_WIDTH'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                       imem_req;
  logic [INST_ADDR_WIDTH-1:0] imem_addr;
  logic                       imem_ack;
  logic [INST_WIDTH-1:0]      imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/inst_fetch_fifo.sv
// Circular FIFO of {addr, inst} entries between memory and decode.
// The head is read straight out of the storage registers; flush empties it in one cycle.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CNT_W-1:0] count,
  output logic         head_valid,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop) && !flush;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; head_valid masks stale contents, so only pointers and count need one.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    count      = count_q;
    head_valid = (count_q != '0);
    head       = head_valid ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, one-outstanding-request memory FSM (IDLE/REQ/DRAIN) and fetch FIFO.
// A redirect with an un-acked request parks in DRAIN until the stale data has been consumed.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_addr,
  inst_fetch_if.master               imem,
  output logic                       inst_valid,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr_out
);

  localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

  fetch_state_e               state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_ADDR_WIDTH-1:0] drain_addr_q, drain_addr_d;

  logic                       req;
  logic [INST_ADDR_WIDTH-1:0] req_addr;
  logic                       fifo_push, fifo_pop;
  logic [CNT_W-1:0]           fifo_count;
  logic                       fifo_valid;
  fetch_entry_t               fifo_head;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    req          = 1'b0;
    req_addr     = pc_q;
    fifo_push    = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        // The count cannot grow while a request waits, so req stays high until ack.
        req = (fifo_count < CNT_W'(FETCH_DEPTH));
        if (redirect) begin
          pc_d = align_pc(redirect_addr);
          if (req && !imem.imem_ack) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (req && imem.imem_ack) begin
          fifo_push = 1'b1;
          pc_d      = pc_q + PC_INC;
        end
      end

      ST_DRAIN: begin
        req      = 1'b1;
        req_addr = drain_addr_q;
        if (redirect)      pc_d    = align_pc(redirect_addr);
        if (imem.imem_ack) state_d = ST_REQ;
      end

      default: state_d = ST_IDLE;
    endcase

    imem.imem_req  = req;
    imem.imem_addr = req ? req_addr : '0;
    fifo_pop       = fifo_valid && !stall && !redirect;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  fetch_fifo #(.DEPTH(FETCH_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (fifo_push),
    .push_data  ('{addr: pc_q, inst: imem.imem_rdata}),
    .pop        (fifo_pop),
    .count      (fifo_count),
    .head_valid (fifo_valid),
    .head       (fifo_head)
  );

  assign inst_valid    = fifo_valid;
  assign inst_out      = fifo_head.inst;
  assign inst_addr_out = fifo_head.addr;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: bench-side memory model with programmable latency and
// a scoreboard of expected {addr, inst} pushed on kept acks and popped when decode accepts.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

`ifdef FETCH_PREFETCH_EN
  localparam int TB_DEPTH = 4;
`else
  localparam int TB_DEPTH = 1;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem          (bus),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_addr_out (inst_addr_out)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          mem_lat = 0;
  bit          mem_busy = 0;
  logic [31:0] mem_addr = '0;
  int          mem_wait = 0;
  bit          drain_pending = 0;
  logic        last_valid = 1'b0;
  logic        last_req = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge, run memory + scoreboard, return at posedge+1.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_valid = inst_valid;
    last_req   = bus.imem_req;

    if (inst_valid && !stall && !redirect) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("inst_addr_out", inst_addr_out, e.addr);
        check("inst_out", inst_out, e.inst);
        pop_log.push_back(inst_addr_out);
      end
    end
    if (redirect) exp_q.delete();

    bus.imem_ack = 1'b0;
    if (mem_busy) check("req_held", 32'(bus.imem_req), 32'd1);
    if (bus.imem_req) begin
      if (mem_busy) begin
        check("req_addr_stable", bus.imem_addr, mem_addr);
      end else begin
        mem_busy = 1;
        mem_addr = bus.imem_addr;
        mem_wait = 0;
        req_log.push_back(bus.imem_addr);
      end
      if (mem_wait == mem_lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = inst_of(mem_addr);
        mem_busy       = 0;
        if (drain_pending) drain_pending = 0;
        else if (!redirect) exp_q.push_back('{addr: mem_addr, inst: inst_of(mem_addr)});
      end else begin
        mem_wait++;
        if (redirect) drain_pending = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_out", inst_out, 32'd0);
    check("rst_inst_addr_out", inst_addr_out, 32'd0);
    exp_q.delete();
    req_log.delete();
    pop_log.delete();
    mem_busy = 0;
    drain_pending = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input int max, output bit found);
    int n0;
    n0 = req_log.size();
    found = 0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      if (req_log.size() > n0) found = 1;
    end
  endtask

  initial begin
    bit found;
    int first_valid;
    int n;
    int hits;

    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    #3;

    // Reset, IDLE cycle, first requests with a zero-latency memory
    do_reset();
    first_valid = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) check("idle_no_req", 32'(last_req), 32'd0);
      if (last_valid && first_valid < 0) first_valid = k;
    end
    check("first_valid_cycle", 32'(first_valid), 32'd2);
    check("req_count_ge3", 32'(req_log.size() >= 3), 32'd1);
    if (req_log.size() >= 3) begin
      check("req_addr_0", req_log[0], 32'h0);
      check("req_addr_1", req_log[1], 32'h4);
      check("req_addr_2", req_log[2], 32'h8);
    end

    // Stall held from reset: requests only until the FIFO fills
    stall = 1'b1;
    do_reset();
    tick();
    for (int k = 0; k < 6; k++) tick();
    check("stall_req_count", 32'(req_log.size()), 32'(TB_DEPTH));
    check("stall_req_low", 32'(last_req), 32'd0);
    stall = 1'b0;
    pop_log.delete();
    for (int i = 0; i < 60 && pop_log.size() < 4; i++) tick();
    check("stall_pops_ge4", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() >= 4) begin
      check("stall_pop_0", pop_log[0], 32'h0);
      check("stall_pop_1", pop_log[1], 32'h4);
      check("stall_pop_2", pop_log[2], 32'h8);
      check("stall_pop_3", pop_log[3], 32'hC);
    end

    // Redirect while a 3-cycle request to 0x10 is pending
    mem_lat = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (req_log.size() > 0 && req_log[$] == 32'h10) found = 1;
    end
    check("drain_req10_seen", 32'(found), 32'd1);
    redirect = 1'b1;
    redirect_addr = 32'h0000_0103;
    pop_log.delete();
    tick();
    redirect = 1'b0;
    tick();
    check("drain_flush_valid", 32'(last_valid), 32'd0);
    wait_req(20, found);
    check("drain_done", 32'(found), 32'd1);
    check("drain_next_addr", req_log[$], 32'h100);
    for (int i = 0; i < 20 && pop_log.size() < 1; i++) tick();
    check("drain_pop_seen", 32'(pop_log.size() >= 1), 32'd1);
    if (pop_log.size() >= 1) check("drain_first_pop", pop_log[0], 32'h100);
    hits = 0;
    foreach (pop_log[i]) if (pop_log[i] == 32'h10) hits++;
    check("drain_no_0x10", 32'(hits), 32'd0);

    // Redirect coincident with ack and stall
    mem_lat = 0;
    do_reset();
    tick();
    redirect = 1'b1;
    redirect_addr = 32'h0000_0200;
    stall = 1'b1;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    check("coinc_acked_addr", req_log[$], 32'h0);
    pop_log.delete();
    tick();
    check("coinc_fifo_empty", 32'(last_valid), 32'd0);
    check("coinc_next_addr", req_log[$], 32'h200);
    for (int i = 0; i < 10 && pop_log.size() < 1; i++) tick();
    check("coinc_pop_seen", 32'(pop_log.size() >= 1), 32'd1);
    if (pop_log.size() >= 1) check("coinc_first_pop", pop_log[0], 32'h200);

    // PC wrap at the top of the address space, then reset mid-request
    redirect = 1'b1;
    redirect_addr = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    n = req_log.size();
    for (int i = 0; i < 20 && req_log.size() < n + 2; i++) tick();
    check("wrap_reqs_seen", 32'(req_log.size() >= n + 2), 32'd1);
    if (req_log.size() >= n + 2) begin
      check("wrap_addr_top", req_log[n], 32'hFFFF_FFFC);
      check("wrap_addr_zero", req_log[n + 1], 32'h0);
    end
    mem_lat = 3;
    wait_req(20, found);
    check("midreq_started", 32'(found), 32'd1);
    tick();
    check("midreq_pending", 32'(last_req), 32'd1);
    do_reset();
    wait_req(20, found);
    check("refetch_seen", 32'(found), 32'd1);
    if (req_log.size() >= 1) check("refetch_reset_pc", req_log[0], 32'h0);
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
